// File: rtl/uart_buf_pkg.sv
// uart_buf_pkg: shared constants and state types for the UART rx replay controller
package uart_buf_pkg;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    typedef enum logic [2:0] {IDLE, REPLAY, CR, LF, FIN} rp_state_t;
    typedef enum logic [1:0] {SRC_NONE, SRC_RAM, SRC_CR, SRC_LF} rp_src_t;
endpackage

// File: rtl/replay_ram.sv
// replay_ram: circular capture store with full/overwrite policy and a registered read port
module replay_ram #(
    parameter int DW        = 8,
    parameter int DEPTH     = 16,
    parameter int AW        = $clog2(DEPTH),
    parameter int OVERWRITE = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic [AW-1:0] rd_base,
    output logic [AW:0]   count,
    output logic          full,
    output logic          ovf
);
    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rd_data_q;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_base_q, rd_base_d;
    logic [AW:0]   count_q, count_d;
    logic          do_wr;

    assign full  = count_q == (AW+1)'(DEPTH);
    assign ovf   = wr_en & ~clr & full;
    assign do_wr = wr_en & ~clr & (~full | (OVERWRITE != 0));

    // A write into a full buffer evicts the oldest entry, so the replay base slides with it.
    always_comb begin
        wr_ptr_d  = clr ? '0 : do_wr ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_base_d = clr ? '0 : (do_wr & full) ? rd_base_q + AW'(1) : rd_base_q;
        count_d   = clr ? '0 : (do_wr & ~full) ? count_q + (AW+1)'(1) : count_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q  <= '0;
            rd_base_q <= '0;
            count_q   <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_base_q <= rd_base_d;
            count_q   <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data;
        if (rd_en) rd_data_q <= mem_q[rd_addr];
    end

    assign rd_data = rd_data_q;
    assign rd_base = rd_base_q;
    assign count   = count_q;
endmodule

// File: rtl/uart_rx_replay_ctl.sv
// uart_rx_replay_ctl: live UART rx forwarding with circular capture and non-destructive replay
module uart_rx_replay_ctl
    import uart_buf_pkg::*;
#(
    parameter int DW          = 8,
    parameter int DEPTH       = 16,
    parameter int AW          = $clog2(DEPTH),
    parameter int OVERWRITE   = 1,
    parameter int APPEND_CRLF = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] rx_data,
    input  logic          rx_data_rdy,
    input  logic          capture,
    input  logic          replay,
    input  logic          erase,
    input  logic          getByte,
    output logic [DW-1:0] ur_rx_data,
    output logic          ur_rx_data_rdy,
    output logic          ur_done,
    output logic [AW:0]   ur_count,
    output logic          ur_full,
    output logic          ur_overrun
);
    localparam rp_state_t TAIL = (APPEND_CRLF != 0) ? CR : FIN;

    rp_state_t     state_q, state_d;
    rp_src_t       src_q, src_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   rem_q, rem_d;
    logic [DW-1:0] hold_q, hold_d;
    logic          hold_vld_q, hold_vld_d;
    logic          ovr_q, ovr_d;
    logic          rd_en, wr_req, busy;
    logic [DW-1:0] ram_rd_data, rep_data;
    logic [AW-1:0] ram_rd_base;
    logic [AW:0]   ram_count;
    logic          ram_full, ram_ovf;

    assign wr_req = rx_data_rdy & capture;
    assign busy   = src_q != SRC_NONE;

    replay_ram #(.DW(DW), .DEPTH(DEPTH), .AW(AW), .OVERWRITE(OVERWRITE)) u_ram (
        .clk     (clk),
        .reset   (reset),
        .clr     (erase),
        .wr_en   (wr_req & (state_q == IDLE)),
        .wr_data (rx_data),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr_q),
        .rd_data (ram_rd_data),
        .rd_base (ram_rd_base),
        .count   (ram_count),
        .full    (ram_full),
        .ovf     (ram_ovf)
    );

    // The last buffered read jumps straight to the trailer so output stays back-to-back.
    always_comb begin
        state_d  = state_q;
        src_d    = SRC_NONE;
        rd_ptr_d = rd_ptr_q;
        rem_d    = rem_q;
        rd_en    = 1'b0;
        if (replay) begin
            state_d  = REPLAY;
            rd_ptr_d = ram_rd_base;
            rem_d    = ram_count;
        end else begin
            case (state_q)
                REPLAY: begin
                    if (rem_q == '0) begin
                        state_d = TAIL;
                    end else if (getByte) begin
                        rd_en    = 1'b1;
                        src_d    = SRC_RAM;
                        rd_ptr_d = rd_ptr_q + AW'(1);
                        rem_d    = rem_q - (AW+1)'(1);
                        state_d  = (rem_q == (AW+1)'(1)) ? TAIL : REPLAY;
                    end
                end
                CR: if (getByte) begin
                    src_d   = SRC_CR;
                    state_d = LF;
                end
                LF: if (getByte) begin
                    src_d   = SRC_LF;
                    state_d = FIN;
                end
                FIN:     state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
        if (erase) begin
            state_d  = IDLE;
            src_d    = SRC_NONE;
            rd_ptr_d = '0;
            rem_d    = '0;
        end
    end

    // Live bytes that collide with replay output park in the hold register until a free cycle.
    always_comb begin
        hold_d     = rx_data_rdy ? rx_data : hold_q;
        hold_vld_d = ~erase & (busy ? (rx_data_rdy | hold_vld_q) : (hold_vld_q & rx_data_rdy));
        ovr_d      = ~erase & (ovr_q | ram_ovf | (wr_req & (state_q != IDLE))
                               | (busy & rx_data_rdy & hold_vld_q));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            src_q      <= SRC_NONE;
            rd_ptr_q   <= '0;
            rem_q      <= '0;
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            rd_ptr_q   <= rd_ptr_d;
            rem_q      <= rem_d;
            hold_q     <= erase ? '0 : hold_d;
            hold_vld_q <= hold_vld_d;
            ovr_q      <= ovr_d;
        end
    end

    assign rep_data = (src_q == SRC_RAM) ? ram_rd_data
                    : DW'((src_q == SRC_CR) ? ASCII_CR : ASCII_LF);

    assign ur_rx_data     = busy ? rep_data : hold_vld_q ? hold_q : rx_data_rdy ? rx_data : '0;
    assign ur_rx_data_rdy = busy | hold_vld_q | rx_data_rdy;
    assign ur_done        = (state_q == FIN) & ~erase;
    assign ur_count       = ram_count;
    assign ur_full        = ram_full;
    assign ur_overrun     = ovr_q;
endmodule

// File: tb/tb_uart_rx_replay_ctl.sv
// tb_uart_rx_replay_ctl: directed vector table plus overwrite-policy sequence for the replay controller
module tb_uart_rx_replay_ctl;
    logic       clk = 1'b0;
    logic       reset, rx_data_rdy, capture, replay, erase, getByte;
    logic [7:0] rx_data;

    logic [7:0] o0_d, o4_d, n4_d;
    logic       o0_rdy, o0_done, o0_full, o0_ovr;
    logic       o4_rdy, o4_done, o4_full, o4_ovr;
    logic       n4_rdy, n4_done, n4_full, n4_ovr;
    logic [4:0] o0_cnt;
    logic [2:0] o4_cnt, n4_cnt;

    int tests = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_rx_replay_ctl u_dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_data_rdy(rx_data_rdy),
        .capture(capture), .replay(replay), .erase(erase), .getByte(getByte),
        .ur_rx_data(o0_d), .ur_rx_data_rdy(o0_rdy), .ur_done(o0_done),
        .ur_count(o0_cnt), .ur_full(o0_full), .ur_overrun(o0_ovr)
    );

    uart_rx_replay_ctl #(.DEPTH(4), .OVERWRITE(1)) u_ow (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_data_rdy(rx_data_rdy),
        .capture(capture), .replay(replay), .erase(erase), .getByte(getByte),
        .ur_rx_data(o4_d), .ur_rx_data_rdy(o4_rdy), .ur_done(o4_done),
        .ur_count(o4_cnt), .ur_full(o4_full), .ur_overrun(o4_ovr)
    );

    uart_rx_replay_ctl #(.DEPTH(4), .OVERWRITE(0)) u_nw (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_data_rdy(rx_data_rdy),
        .capture(capture), .replay(replay), .erase(erase), .getByte(getByte),
        .ur_rx_data(n4_d), .ur_rx_data_rdy(n4_rdy), .ur_done(n4_done),
        .ur_count(n4_cnt), .ur_full(n4_full), .ur_overrun(n4_ovr)
    );

    typedef struct {
        logic       rst, rdy;
        logic [7:0] d;
        logic       cap, rep, ers, gb;
        logic       e_rdy;
        logic [7:0] e_d;
        logic       e_done;
        logic [4:0] e_cnt;
        logic       e_ovr;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic rst, rdy, input logic [7:0] d, input logic cap, rep, ers, gb,
                       input logic e_rdy, input logic [7:0] e_d, input logic e_done,
                       input logic [4:0] e_cnt, input logic e_ovr);
        vq.push_back('{rst, rdy, d, cap, rep, ers, gb, e_rdy, e_d, e_done, e_cnt, e_ovr});
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic rst, rdy, input logic [7:0] d, input logic cap, rep, ers, gb);
        reset = rst; rx_data_rdy = rdy; rx_data = d;
        capture = cap; replay = rep; erase = ers; getByte = gb;
    endtask

    logic [7:0] q4[$], qn[$];
    logic [7:0] exp4[6] = '{8'h03, 8'h04, 8'h05, 8'h06, 8'h0D, 8'h0A};
    logic [7:0] expn[6] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h0D, 8'h0A};

    initial begin
        logic prev_rst;
        int   d4, dn;
        drive(0, 0, 8'h00, 0, 0, 0, 0);
        repeat (2) @(negedge clk);

        //  rst rdy d     cap rep ers gb   e_rdy e_d  done cnt ovr
        add(1, 0, 8'h00, 0, 0, 0, 0,   0, 8'h00, 0, 0, 0);
        add(1, 1, 8'h41, 1, 0, 0, 0,   1, 8'h41, 0, 0, 0);
        add(1, 1, 8'h42, 1, 0, 0, 0,   1, 8'h42, 0, 1, 0);
        add(1, 1, 8'h43, 1, 0, 0, 0,   1, 8'h43, 0, 2, 0);
        add(1, 0, 8'h00, 0, 0, 0, 0,   0, 8'h00, 0, 3, 0);
        add(1, 0, 8'h00, 0, 1, 0, 0,   0, 8'h00, 0, 3, 0);
        add(1, 0, 8'h00, 0, 0, 0, 1,   0, 8'h00, 0, 3, 0);
        add(1, 0, 8'h00, 0, 0, 0, 1,   1, 8'h41, 0, 3, 0);
        add(1, 0, 8'h00, 0, 0, 0, 1,   1, 8'h42, 0, 3, 0);
        add(1, 0, 8'h00, 0, 0, 0, 1,   1, 8'h43, 0, 3, 0);
        add(1, 0, 8'h00, 0, 0, 0, 1,   1, 8'h0D, 0, 3, 0);
        add(1, 0, 8'h00, 0, 0, 0, 1,   1, 8'h0A, 1, 3, 0);
        add(1, 0, 8'h00, 0, 0, 0, 1,   0, 8'h00, 0, 3, 0);
        // second replay: replay+getByte reads nothing; live 0x55 collides with 0x41
        add(1, 0, 8'h00, 0, 1, 0, 1,   0, 8'h00, 0, 3, 0);
        add(1, 0, 8'h00, 0, 0, 0, 1,   0, 8'h00, 0, 3, 0);
        add(1, 1, 8'h55, 1, 0, 0, 0,   1, 8'h41, 0, 3, 0);
        add(1, 0, 8'h00, 0, 0, 0, 0,   1, 8'h55, 0, 3, 1);
        add(1, 0, 8'h00, 0, 0, 0, 1,   0, 8'h00, 0, 3, 1);
        add(1, 0, 8'h00, 0, 0, 0, 1,   1, 8'h42, 0, 3, 1);
        add(1, 0, 8'h00, 0, 0, 0, 1,   1, 8'h43, 0, 3, 1);
        add(1, 0, 8'h00, 0, 0, 0, 1,   1, 8'h0D, 0, 3, 1);
        add(1, 0, 8'h00, 0, 0, 0, 0,   1, 8'h0A, 1, 3, 1);
        add(1, 0, 8'h00, 0, 0, 0, 0,   0, 8'h00, 0, 3, 1);
        // erase after two replayed bytes
        add(1, 0, 8'h00, 0, 1, 0, 0,   0, 8'h00, 0, 3, 1);
        add(1, 0, 8'h00, 0, 0, 0, 1,   0, 8'h00, 0, 3, 1);
        add(1, 0, 8'h00, 0, 0, 0, 1,   1, 8'h41, 0, 3, 1);
        add(1, 0, 8'h00, 0, 0, 1, 1,   1, 8'h42, 0, 3, 1);
        add(1, 0, 8'h00, 0, 0, 0, 1,   0, 8'h00, 0, 0, 0);
        add(1, 0, 8'h00, 0, 0, 0, 1,   0, 8'h00, 0, 0, 0);
        // empty replay: trailer only
        add(1, 0, 8'h00, 0, 1, 0, 0,   0, 8'h00, 0, 0, 0);
        add(1, 0, 8'h00, 0, 0, 0, 1,   0, 8'h00, 0, 0, 0);
        add(1, 0, 8'h00, 0, 0, 0, 1,   0, 8'h00, 0, 0, 0);
        add(1, 0, 8'h00, 0, 0, 0, 1,   1, 8'h0D, 0, 0, 0);
        add(1, 0, 8'h00, 0, 0, 0, 0,   1, 8'h0A, 1, 0, 0);
        add(1, 0, 8'h00, 0, 0, 0, 0,   0, 8'h00, 0, 0, 0);
        // reset mid-replay
        add(1, 1, 8'h61, 1, 0, 0, 0,   1, 8'h61, 0, 0, 0);
        add(1, 0, 8'h00, 0, 1, 0, 0,   0, 8'h00, 0, 1, 0);
        add(1, 0, 8'h00, 0, 0, 0, 1,   0, 8'h00, 0, 1, 0);
        add(0, 0, 8'h00, 0, 0, 0, 1,   1, 8'h61, 0, 1, 0);
        add(1, 0, 8'h00, 0, 0, 0, 1,   0, 8'h00, 0, 0, 0);
        add(1, 0, 8'h00, 0, 0, 0, 1,   0, 8'h00, 0, 0, 0);
        // erase and replay together: erase wins
        add(1, 1, 8'h71, 1, 0, 0, 0,   1, 8'h71, 0, 0, 0);
        add(1, 0, 8'h00, 0, 1, 1, 0,   0, 8'h00, 0, 1, 0);
        add(1, 0, 8'h00, 0, 0, 0, 1,   0, 8'h00, 0, 0, 0);
        add(1, 0, 8'h00, 0, 0, 0, 1,   0, 8'h00, 0, 0, 0);
        add(1, 0, 8'h00, 0, 0, 0, 1,   0, 8'h00, 0, 0, 0);
        add(1, 0, 8'h00, 0, 0, 0, 0,   0, 8'h00, 0, 0, 0);

        prev_rst = 1'b0;
        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            drive(vq[i].rst, vq[i].rdy, vq[i].d, vq[i].cap, vq[i].rep, vq[i].ers, vq[i].gb);
            #1;
            chk($sformatf("v%0d rdy", i), o0_rdy, vq[i].e_rdy);
            if (vq[i].e_rdy || !prev_rst) chk($sformatf("v%0d data", i), o0_d, vq[i].e_d);
            chk($sformatf("v%0d done", i), o0_done, vq[i].e_done);
            chk($sformatf("v%0d count", i), o0_cnt, vq[i].e_cnt);
            chk($sformatf("v%0d overrun", i), o0_ovr, vq[i].e_ovr);
            prev_rst = vq[i].rst;
        end

        // DEPTH=4 overwrite policy: six captures, then a full replay
        @(negedge clk);
        drive(0, 0, 8'h00, 0, 0, 0, 0);
        @(negedge clk);
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            drive(1, 1, 8'(i), 1, 0, 0, 0);
        end
        @(negedge clk);
        drive(1, 0, 8'h00, 0, 0, 0, 0);
        #1;
        chk("ow count", o4_cnt, 4);
        chk("ow full", o4_full, 1);
        chk("ow overrun", o4_ovr, 1);
        chk("nw count", n4_cnt, 4);
        chk("nw full", n4_full, 1);
        chk("nw overrun", n4_ovr, 1);
        d4 = 0;
        dn = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            drive(1, 0, 8'h00, 0, k == 0, 0, k != 0);
            #1;
            if (o4_rdy) q4.push_back(o4_d);
            if (n4_rdy) qn.push_back(n4_d);
            d4 += int'(o4_done);
            dn += int'(n4_done);
        end
        chk("ow bytes", q4.size(), 6);
        chk("nw bytes", qn.size(), 6);
        chk("ow done pulses", d4, 1);
        chk("nw done pulses", dn, 1);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("ow byte%0d", i), (i < q4.size()) ? q4[i] : 8'hFF, exp4[i]);
            chk($sformatf("nw byte%0d", i), (i < qn.size()) ? qn[i] : 8'hFF, expn[i]);
        end
        chk("ow count after", o4_cnt, 4);
        chk("nw count after", n4_cnt, 4);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
